// File: rtl/ls_down_timer.sv
// ls_down_timer: presettable, cascadable down-counter/timer with one-shot and periodic modes
module ls_down_timer #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             CLR_n,
  input  logic [WIDTH-1:0] D,
  input  logic             LOAD_n,
  input  logic             ENP,
  input  logic             ENT,
  input  logic             RELOAD,
  output logic [WIDTH-1:0] Q,
  output logic             BO,
  output logic             DONE,
  output logic [1:0]       STATE
);
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, EXPIRED = 2'b10, BAD = 2'b11} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] r, q_n, r_n;
  logic done_n, cnt_en;
  always_ff @(posedge CLK or negedge CLR_n)
    if (!CLR_n) begin
      state <= IDLE;
      Q     <= '0;
      r     <= '0;
      DONE  <= 1'b0;
    end else begin
      state <= state_n;
      Q     <= q_n;
      r     <= r_n;
      DONE  <= done_n;
    end
  assign cnt_en = ENP & ENT & (state == RUN) & LOAD_n;
  always_comb begin
    state_n = state;
    q_n     = Q;
    r_n     = r;
    done_n  = 1'b0;
    if (!LOAD_n) begin
      q_n     = D;
      r_n     = D;
      state_n = |D ? RUN : IDLE;
    end else if (state == BAD) begin
      state_n = IDLE;
    end else if (cnt_en) begin
      if (Q > WIDTH'(1)) begin
        q_n = Q - WIDTH'(1);
      end else if (Q == WIDTH'(1)) begin
        q_n     = '0;
        done_n  = 1'b1;
        state_n = RELOAD ? RUN : EXPIRED;
      end else begin
        q_n     = RELOAD ? r : Q;
        state_n = RELOAD ? RUN : EXPIRED;
      end
    end
  end
  assign BO    = ENT & (Q == '0) & (state != IDLE);
  assign STATE = state;
endmodule

// File: tb/tb_ls_down_timer.sv
// tb_ls_down_timer: directed stimulus with a per-cycle reference model and a two-stage cascade check
module tb_ls_down_timer;
  logic CLK = 1'b0, CLR_n = 1'b0, LOAD_n = 1'b1, ENP = 1'b0, ENT = 1'b0, RELOAD = 1'b0;
  logic [3:0] D = '0, Q;
  logic BO, DONE;
  logic [1:0] STATE;
  logic c_ld_n = 1'b1, c_en = 1'b0;
  logic [3:0] lo_q, hi_q;
  logic lo_bo, hi_bo, lo_done, hi_done;
  logic [1:0] lo_st, hi_st;
  int n_cmp = 0, n_bad = 0;
  int m_q = 0, m_r = 0, m_st = 0, m_done = 0;

  always #5 CLK = ~CLK;

  ls_down_timer #(.WIDTH(4)) dut (
    .CLK(CLK), .CLR_n(CLR_n), .D(D), .LOAD_n(LOAD_n), .ENP(ENP), .ENT(ENT),
    .RELOAD(RELOAD), .Q(Q), .BO(BO), .DONE(DONE), .STATE(STATE)
  );
  ls_down_timer #(.WIDTH(4)) lo (
    .CLK(CLK), .CLR_n(CLR_n), .D(4'h5), .LOAD_n(c_ld_n), .ENP(c_en), .ENT(c_en),
    .RELOAD(1'b1), .Q(lo_q), .BO(lo_bo), .DONE(lo_done), .STATE(lo_st)
  );
  ls_down_timer #(.WIDTH(4)) hi (
    .CLK(CLK), .CLR_n(CLR_n), .D(4'h1), .LOAD_n(c_ld_n), .ENP(c_en), .ENT(lo_bo),
    .RELOAD(1'b1), .Q(hi_q), .BO(hi_bo), .DONE(hi_done), .STATE(hi_st)
  );

  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: a remaining-count timer; states 0 idle, 1 running, 2 expired
  always @(posedge CLK or negedge CLR_n)
    if (!CLR_n) begin
      m_q <= 0; m_r <= 0; m_st <= 0; m_done <= 0;
    end else begin
      m_done <= 0;
      if (!LOAD_n) begin
        m_q <= int'(D); m_r <= int'(D); m_st <= (D == 0) ? 0 : 1;
      end else if (m_st == 1 && ENP && ENT) begin
        if (m_q == 0) begin
          if (RELOAD) m_q <= m_r;
          else m_st <= 2;
        end else begin
          m_q <= m_q - 1;
          if (m_q == 1) begin
            m_done <= 1;
            if (!RELOAD) m_st <= 2;
          end
        end
      end
    end

  always @(negedge CLK)
    if (CLR_n) begin
      chk("model_q", int'(Q), m_q);
      chk("model_state", int'(STATE), m_st);
      chk("model_done", int'(DONE), m_done);
      chk("model_bo", int'(BO), (ENT && m_q == 0 && m_st != 0) ? 1 : 0);
    end

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  task automatic load(input logic [3:0] d);
    LOAD_n = 1'b0;
    D = d;
    tick();
    LOAD_n = 1'b1;
  endtask

  initial begin
    int os_q[4] = '{3, 2, 1, 0};
    int pr_q[9] = '{2, 1, 0, 2, 1, 0, 2, 1, 0};
    int ps_q[9] = '{6, 5, 4, 4, 4, 4, 3, 2, 1};
    int cs_q[13] = '{8'h15, 8'h14, 8'h13, 8'h12, 8'h11, 8'h10, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h00, 8'h15};
    #2;
    chk("por_q", int'(Q), 0);
    chk("por_state", int'(STATE), 0);
    chk("por_bo", int'(BO), 0);
    tick();
    CLR_n = 1'b1;
    ENP = 1'b1; ENT = 1'b1;
    tick();
    load(4'd7);
    tick(); tick();
    chk("pre_reset_q", int'(Q), 5);
    CLR_n = 1'b0;
    #1;
    chk("async_reset_q", int'(Q), 0);
    chk("async_reset_state", int'(STATE), 0);
    chk("async_reset_done", int'(DONE), 0);
    chk("async_reset_bo", int'(BO), 0);
    tick();
    CLR_n = 1'b1;
    tick(); tick();
    chk("hold_after_reset_q", int'(Q), 0);
    chk("hold_after_reset_state", int'(STATE), 0);
    RELOAD = 1'b0;
    load(4'd3);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      chk("oneshot_q", int'(Q), os_q[i]);
      chk("oneshot_done", int'(DONE), i == 3 ? 1 : 0);
    end
    chk("oneshot_state", int'(STATE), 2);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("expired_q", int'(Q), 0);
      chk("expired_bo", int'(BO), 1);
      chk("expired_done", int'(DONE), 0);
    end
    ENT = 1'b0;
    #1;
    chk("expired_bo_ent0", int'(BO), 0);
    ENT = 1'b1;
    RELOAD = 1'b1;
    load(4'd2);
    for (int i = 0; i < 9; i++) begin
      if (i > 0) tick();
      chk("periodic_q", int'(Q), pr_q[i]);
      chk("periodic_done", int'(DONE), pr_q[i] == 0 ? 1 : 0);
      chk("periodic_bo", int'(BO), pr_q[i] == 0 ? 1 : 0);
      chk("periodic_state", int'(STATE), 1);
    end
    RELOAD = 1'b0;
    load(4'd6);
    for (int i = 0; i < 9; i++) begin
      if (i > 0) tick();
      chk("pause_q", int'(Q), ps_q[i]);
      ENP = (i >= 2 && i < 5) ? 1'b0 : 1'b1;
    end
    load(4'd9);
    chk("load_wins_q", int'(Q), 9);
    chk("load_wins_done", int'(DONE), 0);
    chk("load_wins_state", int'(STATE), 1);
    load(4'd0);
    for (int i = 0; i < 4; i++) begin
      chk("zero_q", int'(Q), 0);
      chk("zero_state", int'(STATE), 0);
      chk("zero_bo", int'(BO), 0);
      chk("zero_done", int'(DONE), 0);
      tick();
    end
    c_en = 1'b1;
    c_ld_n = 1'b0;
    tick();
    c_ld_n = 1'b1;
    for (int i = 0; i < 13; i++) begin
      if (i > 0) tick();
      chk("cascade_q", int'({hi_q, lo_q}), cs_q[i]);
      chk("cascade_hi_done", int'(hi_done), i == 6 ? 1 : 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ls_down_timer.md
Name: ls_down_timer

Overview:
- Synchronous, presettable, cascadable down-counter/timer. It is the counting-down counterpart of the team's 4-bit up-counter.
- Loads a start value, decrements on enable, and signals terminal count with a one-cycle DONE pulse and a combinational borrow output (BO) for chaining stages.
- Supports one-shot and periodic (auto-reload) modes. Used for timeouts, baud/tick dividers and delay generation.

Parameters:
- WIDTH, 4, counter and reload register width in bits (legal range 2 to 16).

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- CLR_n  input  1  reset, asynchronous, active-low.
- D  input  WIDTH  parallel load value; also captured as the reload value.
- LOAD_n  input  1  synchronous parallel load enable, active-low.
- ENP  input  1  count enable, parallel.
- ENT  input  1  count enable, trickle; also gates BO.
- RELOAD  input  1  mode select, sampled every cycle: 1 = periodic, 0 = one-shot.
- Q  output  WIDTH  current count.
- BO  output  1  borrow out (terminal count), combinational.
- DONE  output  1  registered one-cycle expiry pulse.
- STATE  output  2  FSM state: 00 IDLE, 01 RUN, 10 EXPIRED, 11 unused.

Behaviour:
- Registers: Q, reload register R (WIDTH bits), FSM state, DONE.
- Reset (CLR_n=0), asynchronous, takes effect immediately including mid-count:
  - Q=0, R=0, STATE=IDLE, DONE=0.
  - BO=0 because STATE=IDLE.
- Priority at each rising edge: CLR_n, then LOAD_n, then count.
- Load (LOAD_n=0), in any state, regardless of ENP/ENT:
  - Q<=D and R<=D; DONE<=0.
  - STATE<=RUN if D!=0, otherwise STATE<=IDLE.
- Count enable: cnt_en = ENP & ENT & (STATE==RUN) & LOAD_n.
- RUN with cnt_en=0: Q, R and STATE hold; DONE<=0. Disabling the enable is a pause and causes no state change.
- RUN with cnt_en=1:
  - Q>1: Q<=Q-1; DONE<=0.
  - Q==1: Q<=0; DONE<=1 for one cycle. If RELOAD=0, STATE<=EXPIRED; if RELOAD=1, STATE stays RUN.
  - Q==0 (periodic mode only): Q<=R; DONE<=0. Period = R+1 enabled cycles, with DONE once per period.
  - Q==0 with RELOAD=0, reachable only if RELOAD was changed mid-count: STATE<=EXPIRED, Q holds 0, no DONE.
- IDLE and EXPIRED:
  - Q holds (0 in EXPIRED); count enables are ignored; DONE<=0.
  - Only a load leaves these states. EXPIRED is sticky.
- BO = ENT & (Q==0) & (STATE!=IDLE), combinational.
  - In periodic mode it is asserted during the zero cycle, which allows cascading: the low stage's BO drives the high stage's ENT.
  - In EXPIRED it follows ENT.
- DONE is registered: it is high in the cycle after the edge where Q went from 1 to 0, and low in all other cycles.
- Arithmetic is WIDTH bits, unsigned. There is no underflow below 0 in one-shot mode. Reload from 0 to R is the only wrap.
- STATE encoding 11 is never entered. If it is reached (for example after an upset), the next edge forces IDLE.
- Simultaneous events:
  - LOAD_n=0 together with a cnt_en condition: the load wins and no DONE is produced, even if Q==1.
  - A load on the same edge as a 1-to-0 transition that would otherwise occur: the load wins.
  - CLR_n deasserted asynchronously: the first active edge after release is evaluated normally.

Test Plan:
- Reset: CLR_n=0 mid-RUN with Q=5 -> Q=0, STATE=00, DONE=0, BO=0 without waiting for a clock edge; values hold until a load.
- One-shot: load D=3, RELOAD=0, ENP=ENT=1 -> Q sequence 3,2,1,0; DONE=1 for exactly one cycle after the 1-to-0 edge; STATE=10; Q stays 0 for 10 further cycles; BO=1 while ENT=1.
- Periodic: load D=2, RELOAD=1, enables high for 9 cycles -> Q sequence 2,1,0,2,1,0,2,1,0; DONE pulses every 3 cycles; BO=1 only in the Q=0 cycles; STATE stays 01.
- Pause and priority: during a count from 6, drop ENP for 3 cycles -> Q holds at 4. Assert LOAD_n=0 with D=9 while Q==1 and enables high -> Q=9, no DONE pulse.
- Zero load: load D=0 with enables high -> STATE=00, Q=0, BO=0, DONE never asserts.
- Cascade with two WIDTH=4 instances in periodic mode, low BO driving high ENT, load 0x15 (high nibble 1, low nibble 5) -> combined Q decrements 0x15 to 0x10, then low wraps to 5 and high decrements to 0.
